vita_frame_packer: RTL and testbench

Parametrised frame capture and pixel packer for the VITA2000 parallel sensor path, and the next generation of the current 4-lane, 8-bit recorder. Each accepted beat carries one pixel per lane. The block gathers `BEATS` beats into one output word for the frame buffer write port. It also adds armed single-shot or continuous capture, zero-padded flush of partial words at frame end, start/end-of-frame markers, a frame counter and sticky sync-error flags.

---
 rtl/vita_frame_packer.sv | 155 +++++++++++++++
 tb/tb_vita_frame_packer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vita_frame_packer.sv
// VITA2000 capture front end: packs BEATS lane beats into one frame-buffer word,
// with armed single-shot/continuous capture, frame markers, frame count and sticky sync errors.
module vita_frame_packer #(
    parameter int  LANES = 4,
    parameter int  PIX_W = 8,
    parameter int  BEATS = 2,
    parameter int  CNT_W = 16,
    localparam int OUT_W = LANES * PIX_W * BEATS
) (
    input  logic                     par_clock,
    input  logic                     rst,
    input  logic [LANES*PIX_W-1:0]   cam_d,
    input  logic                     FS,
    input  logic                     FE,
    input  logic                     INV,
    input  logic                     REC,
    input  logic                     arm,
    input  logic                     cont,
    output logic                     we,
    output logic [OUT_W-1:0]         pixels,
    output logic                     sof,
    output logic                     eof,
    output logic [CNT_W-1:0]         frame_count,
    output logic                     err_abort,
    output logic                     err_sync
);

    localparam int BEAT_W = LANES * PIX_W;
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_ARMED = 3'b010,
        S_CAPT  = 3'b100
    } state_e;

    state_e           state_q, state_d;
    logic             accept, start, last, abort, resync;
    logic [IDX_W-1:0] beat_q, beat_d, idx;
    logic [OUT_W-1:0] acc_q, acc_d, word, pixels_q, pixels_d;
    logic             first_q, first_d, complete;
    logic             we_q, we_d, sof_q, sof_d, eof_q, eof_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_abort_q, err_abort_d, err_sync_q, err_sync_d;

    always_ff @(posedge par_clock) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state plus the beat-level events that the datapath consumes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        accept  = 1'b0;
        start   = 1'b0;
        last    = 1'b0;
        abort   = 1'b0;
        resync  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (FS && !INV) begin
                    accept  = 1'b1;
                    start   = 1'b1;
                    last    = FE;
                    state_d = FE ? (cont ? S_ARMED : S_IDLE) : S_CAPT;
                end
            end
            S_CAPT: begin
                if (INV) begin
                    abort   = 1'b1;
                    state_d = cont ? S_ARMED : S_IDLE;
                end else if (FS) begin
                    resync = 1'b1;
                    accept = 1'b1;
                    start  = 1'b1;
                end else if (REC) begin
                    accept = 1'b1;
                    last   = FE;
                    if (FE) state_d = cont ? S_ARMED : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Packing datapath; the accumulator is kept zero between words so a frame-end
    // word carries zeros in every slot it never filled.
    always_comb begin
        idx  = start ? '0 : beat_q;
        word = start ? '0 : acc_q;
        word[int'(idx) * BEAT_W +: BEAT_W] = cam_d;
        complete = accept && ((idx == IDX_W'(BEATS - 1)) || last);

        we_d     = complete;
        pixels_d = complete ? word : pixels_q;
        sof_d    = complete && (start || first_q);
        eof_d    = complete && last;
        count_d  = (complete && last) ? count_q + 1'b1 : count_q;

        acc_d   = acc_q;
        beat_d  = beat_q;
        first_d = first_q;
        if (abort || complete) begin
            acc_d   = '0;
            beat_d  = '0;
            first_d = 1'b0;
        end else if (accept) begin
            acc_d   = word;
            beat_d  = idx + 1'b1;
            first_d = start || first_q;
        end

        err_abort_d = abort  || (err_abort_q && !arm);
        err_sync_d  = resync || (err_sync_q  && !arm);
    end

    always_ff @(posedge par_clock) begin
        if (rst) begin
            acc_q       <= '0;
            beat_q      <= '0;
            first_q     <= 1'b0;
            we_q        <= 1'b0;
            pixels_q    <= '0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            count_q     <= '0;
            err_abort_q <= 1'b0;
            err_sync_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            first_q     <= first_d;
            we_q        <= we_d;
            pixels_q    <= pixels_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            count_q     <= count_d;
            err_abort_q <= err_abort_d;
            err_sync_q  <= err_sync_d;
        end
    end

    assign we          = we_q;
    assign pixels      = pixels_q;
    assign sof         = sof_q;
    assign eof         = eof_q;
    assign frame_count = count_q;
    assign err_abort   = err_abort_q;
    assign err_sync    = err_sync_q;

endmodule

// File: tb/tb_vita_frame_packer.sv
// Bench for vita_frame_packer: frames are described as beat lists and the expected
// output words are derived per frame from the packing rules, then matched against the captured we words.
module tb_vita_frame_packer;

    localparam int LANES = 4;
    localparam int PIX_W = 8;
    localparam int BEATS = 2;
    localparam int CNT_W = 16;
    localparam int LW    = LANES * PIX_W;
    localparam int OUT_W = LW * BEATS;

    typedef struct packed {
        logic [OUT_W-1:0] pix;
        logic             sof;
        logic             eof;
        int               cyc;
    } word_t;

    logic             par_clock = 1'b0;
    logic             rst = 1'b1;
    logic [LW-1:0]    cam_d = '0;
    logic             FS = 1'b0, FE = 1'b0, INV = 1'b0, REC = 1'b0, arm = 1'b0, cont = 1'b0;
    logic             we, sof, eof, err_abort, err_sync;
    logic [OUT_W-1:0] pixels;
    logic [CNT_W-1:0] frame_count;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            exp_count = 0;
    bit            exp_abort = 1'b0;
    bit            exp_sync = 1'b0;
    word_t         exp_q[$];
    word_t         obs_q[$];
    word_t         mon_w;
    logic [LW-1:0] fdata[$];

    vita_frame_packer #(.LANES(LANES), .PIX_W(PIX_W), .BEATS(BEATS), .CNT_W(CNT_W)) dut (
        .par_clock(par_clock), .rst(rst), .cam_d(cam_d), .FS(FS), .FE(FE), .INV(INV),
        .REC(REC), .arm(arm), .cont(cont), .we(we), .pixels(pixels), .sof(sof), .eof(eof),
        .frame_count(frame_count), .err_abort(err_abort), .err_sync(err_sync)
    );

    always #5 par_clock = ~par_clock;
    always @(posedge par_clock) cyc <= cyc + 1;

    always @(negedge par_clock) begin
        if (we === 1'b1) begin
            mon_w.pix = pixels;
            mon_w.sof = sof;
            mon_w.eof = eof;
            mon_w.cyc = cyc;
            obs_q.push_back(mon_w);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // One input cycle; tag is the cycle number whose edge samples these inputs.
    task automatic drive(input bit fs, input bit fe, input bit inv, input bit rec,
                         input bit a, input logic [LW-1:0] d, output int tag);
        FS = fs; FE = fe; INV = inv; REC = rec; arm = a; cam_d = d;
        tag = cyc + 1;
        @(posedge par_clock);
        #1;
    endtask

    task automatic idle(input int n);
        int t;
        repeat (n) drive(0, 0, 0, 0, 0, '0, t);
    endtask

    // Inter-frame noise: no FS/INV, so nothing here may be captured.
    task automatic noise(input int n);
        int t;
        repeat (n) drive(0, 1'($urandom), 0, 1'($urandom), 0, LW'($urandom), t);
    endtask

    task automatic pulse_arm();
        int t;
        drive(0, 0, 0, 0, 1, '0, t);
        exp_abort = 1'b0;
        exp_sync  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_count = 0;
        exp_abort = 1'b0;
        exp_sync  = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic fill_random(input int n);
        fdata.delete();
        repeat (n) fdata.push_back(LW'($urandom));
    endtask

    // Drives fdata as one frame. abort_at >= 1 sends INV after that many beats.
    // When captured, the expected words are built from the beat list directly.
    task automatic send_frame(input int abort_at, input bit captured, input bit gaps);
        int               n, nacc, nw, t, li;
        int               tags[$];
        bit               ab;
        logic [OUT_W-1:0] p;
        word_t            e;
        n    = fdata.size();
        ab   = (abort_at >= 0);
        nacc = ab ? abort_at : n;
        for (int i = 0; i < nacc; i++) begin
            if (gaps && i > 0) repeat ($urandom_range(0, 2)) drive(0, 1'($urandom), 0, 0, 0, LW'($urandom), t);
            drive(i == 0, !ab && (i == n - 1), 0, (i == 0) ? 1'($urandom) : 1'b1, 0, fdata[i], t);
            tags.push_back(t);
        end
        if (ab) drive(0, 1'($urandom), 1, 1'($urandom), 0, LW'($urandom), t);
        if (captured) begin
            nw = ab ? nacc / BEATS : (n + BEATS - 1) / BEATS;
            for (int w = 0; w < nw; w++) begin
                p = '0;
                for (int j = 0; j < BEATS; j++)
                    if (w * BEATS + j < nacc) p[j*LW +: LW] = fdata[w * BEATS + j];
                li    = (w * BEATS + BEATS - 1 < nacc) ? w * BEATS + BEATS - 1 : nacc - 1;
                e.pix = p;
                e.sof = (w == 0);
                e.eof = !ab && (w == nw - 1);
                e.cyc = tags[li];
                exp_q.push_back(e);
            end
            if (ab) exp_abort = 1'b1;
            else    exp_count = (exp_count + 1) % (1 << CNT_W);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++;
        if ({we, sof, eof, err_abort, err_sync} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: we/sof/eof/err_abort/err_sync=%b, expected 00000",
                     {we, sof, eof, err_abort, err_sync});
        end
        checks++;
        if (pixels !== '0) begin errors++; $display("FAIL reset_pixels: got %h, expected 0", pixels); end
        checks++;
        if (frame_count !== '0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", frame_count); end
        do_reset();
    endtask

    task automatic test_basic();
        cont = 1'b0;
        pulse_arm();
        fdata = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        send_frame(-1, 1, 0);
        fill_random(2);
        send_frame(-1, 0, 0);   // FSM must be back in IDLE: no capture without arm
        idle(2);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_words: got %0d words, expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL basic_word%0d: got pix=%h sof=%b eof=%b cyc=%0d, expected pix=%h sof=%b eof=%b cyc=%0d",
                         k, obs_q[k].pix, obs_q[k].sof, obs_q[k].eof, obs_q[k].cyc, exp_q[k].pix, exp_q[k].sof, exp_q[k].eof, exp_q[k].cyc);
            end
        end
        if (obs_q.size() >= 2) begin
            checks++;
            if (obs_q[0].pix !== 64'h0706050403020100 || obs_q[1].pix !== 64'h0F0E0D0C0B0A0908) begin
                errors++;
                $display("FAIL basic_pixels: got %h %h, expected 0706050403020100 0f0e0d0c0b0a0908", obs_q[0].pix, obs_q[1].pix);
            end
        end
        checks++;
        if (frame_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL basic_count: got %0d, expected %0d", frame_count, exp_count); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_odd();
        pulse_arm();
        fill_random(3);
        send_frame(-1, 1, 1);
        idle(2);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL odd_words: got %0d words, expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL odd_word%0d: got pix=%h sof=%b eof=%b cyc=%0d, expected pix=%h sof=%b eof=%b cyc=%0d",
                         k, obs_q[k].pix, obs_q[k].sof, obs_q[k].eof, obs_q[k].cyc, exp_q[k].pix, exp_q[k].sof, exp_q[k].eof, exp_q[k].cyc);
            end
        end
        if (obs_q.size() >= 2) begin
            checks++;
            if (obs_q[1].pix[OUT_W-1:LW] !== '0 || obs_q[1].eof !== 1'b1) begin
                errors++;
                $display("FAIL odd_pad: got upper=%h eof=%b, expected upper=0 eof=1", obs_q[1].pix[OUT_W-1:LW], obs_q[1].eof);
            end
        end
        checks++;
        if (frame_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL odd_count: got %0d, expected %0d", frame_count, exp_count); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_abort();
        int t;
        pulse_arm();
        fill_random(1);
        send_frame(1, 1, 0);
        idle(2);
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL abort_words: got %0d words, expected 0", obs_q.size()); end
        checks++;
        if (err_abort !== exp_abort) begin errors++; $display("FAIL abort_flag: got %b, expected %b", err_abort, exp_abort); end
        checks++;
        if (frame_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL abort_count: got %0d, expected %0d", frame_count, exp_count); end
        pulse_arm();
        idle(1);
        checks++;
        if (err_abort !== 1'b0) begin errors++; $display("FAIL abort_clear: got %b, expected 0", err_abort); end
        // arm coinciding with an abort: the set must win
        drive(1, 0, 0, 1, 0, LW'($urandom), t);
        drive(0, 0, 1, 0, 1, '0, t);
        exp_abort = 1'b1;
        idle(1);
        checks++;
        if (err_abort !== exp_abort) begin errors++; $display("FAIL abort_set_wins: got %b, expected 1", err_abort); end
        pulse_arm();
        idle(1);
        checks++;
        if (err_abort !== 1'b0 || obs_q.size() !== 0) begin
            errors++;
            $display("FAIL abort_reclear: got flag=%b words=%0d, expected flag=0 words=0", err_abort, obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_resync();
        int t;
        drive(1, 0, 0, 1, 0, LW'($urandom), t);   // old frame, one beat, then FS again
        fill_random(4);
        send_frame(-1, 1, 1);
        exp_sync = 1'b1;
        idle(2);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL resync_words: got %0d words, expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL resync_word%0d: got pix=%h sof=%b eof=%b cyc=%0d, expected pix=%h sof=%b eof=%b cyc=%0d",
                         k, obs_q[k].pix, obs_q[k].sof, obs_q[k].eof, obs_q[k].cyc, exp_q[k].pix, exp_q[k].sof, exp_q[k].eof, exp_q[k].cyc);
            end
        end
        checks++;
        if (err_sync !== exp_sync || err_abort !== 1'b0) begin
            errors++;
            $display("FAIL resync_flags: got sync=%b abort=%b, expected sync=1 abort=0", err_sync, err_abort);
        end
        checks++;
        if (frame_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL resync_count: got %0d, expected %0d", frame_count, exp_count); end
        pulse_arm();
        idle(1);
        checks++;
        if (err_sync !== 1'b0) begin errors++; $display("FAIL resync_clear: got %b, expected 0", err_sync); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_cont();
        for (int mode = 1; mode >= 0; mode--) begin
            do_reset();
            cont = 1'(mode);
            pulse_arm();
            for (int f = 0; f < 3; f++) begin
                fill_random($urandom_range(1, 6));
                send_frame(-1, (mode == 1) || (f == 0), 1);
                noise($urandom_range(0, 3));
            end
            idle(2);
            checks++;
            if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL cont%0d_words: got %0d words, expected %0d", mode, obs_q.size(), exp_q.size()); end
            foreach (exp_q[k]) if (k < obs_q.size()) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL cont%0d_word%0d: got pix=%h sof=%b eof=%b cyc=%0d, expected pix=%h sof=%b eof=%b cyc=%0d",
                             mode, k, obs_q[k].pix, obs_q[k].sof, obs_q[k].eof, obs_q[k].cyc, exp_q[k].pix, exp_q[k].sof, exp_q[k].eof, exp_q[k].cyc);
                end
            end
            checks++;
            if (frame_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL cont%0d_count: got %0d, expected %0d", mode, frame_count, exp_count); end
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_single_beat();
        cont = 1'b0;
        pulse_arm();
        fill_random(1);
        send_frame(-1, 1, 0);
        idle(2);
        checks++;
        if (obs_q.size() !== 1) begin errors++; $display("FAIL single_words: got %0d words, expected 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL single_word: got pix=%h sof=%b eof=%b cyc=%0d, expected pix=%h sof=%b eof=%b cyc=%0d",
                         obs_q[0].pix, obs_q[0].sof, obs_q[0].eof, obs_q[0].cyc, exp_q[0].pix, exp_q[0].sof, exp_q[0].eof, exp_q[0].cyc);
            end
            checks++;
            if (obs_q[0].pix[OUT_W-1:LW] !== '0 || {obs_q[0].sof, obs_q[0].eof} !== 2'b11) begin
                errors++;
                $display("FAIL single_markers: got upper=%h sof/eof=%b%b, expected upper=0 sof/eof=11",
                         obs_q[0].pix[OUT_W-1:LW], obs_q[0].sof, obs_q[0].eof);
            end
        end
        checks++;
        if (frame_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL single_count: got %0d, expected %0d", frame_count, exp_count); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_rst_mid();
        int t;
        pulse_arm();
        drive(1, 0, 0, 1, 0, 32'hA5A5_0001, t);
        drive(0, 0, 0, 1, 0, 32'h5A5A_0002, t);   // completes one word, pixels now nonzero
        drive(0, 0, 0, 1, 0, 32'h1234_5678, t);   // partial word pending
        obs_q.delete();
        rst = 1'b1;
        drive(0, 1, 0, 1, 0, 32'h9ABC_DEF0, t);   // would complete the frame without reset
        checks++;
        if ({we, sof, eof, err_abort, err_sync} !== 5'b0 || pixels !== '0 || frame_count !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got flags=%b pixels=%h count=%0d, expected all zero",
                     {we, sof, eof, err_abort, err_sync}, pixels, frame_count);
        end
        rst = 1'b0;
        exp_count = 0;
        drive(0, 0, 0, 1, 0, LW'($urandom), t);
        drive(0, 1, 0, 1, 0, LW'($urandom), t);
        idle(2);
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL rst_mid_words: got %0d words, expected 0", obs_q.size()); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        bit live;
        int n, nf, ab;
        for (int it = 0; it < 12; it++) begin
            cont = 1'($urandom);
            pulse_arm();
            live = 1'b1;
            nf = $urandom_range(1, 4);
            for (int f = 0; f < nf; f++) begin
                n = $urandom_range(1, 6);
                fill_random(n);
                ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n) : -1;
                send_frame(ab, live, 1);
                if (!cont) live = 1'b0;
                noise($urandom_range(0, 2));
            end
            idle(2);
            checks++;
            if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_words: got %0d words, expected %0d", it, obs_q.size(), exp_q.size()); end
            foreach (exp_q[k]) if (k < obs_q.size()) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d: got pix=%h sof=%b eof=%b cyc=%0d, expected pix=%h sof=%b eof=%b cyc=%0d",
                             it, k, obs_q[k].pix, obs_q[k].sof, obs_q[k].eof, obs_q[k].cyc, exp_q[k].pix, exp_q[k].sof, exp_q[k].eof, exp_q[k].cyc);
                end
            end
            checks++;
            if (frame_count !== CNT_W'(exp_count) || err_abort !== exp_abort || err_sync !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_status: got count=%0d abort=%b sync=%b, expected count=%0d abort=%b sync=0",
                         it, frame_count, err_abort, err_sync, exp_count, exp_abort);
            end
            exp_q.delete(); obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd();
        test_abort();
        test_resync();
        test_cont();
        test_single_beat();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
